// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port video RAM between pixel scanout and a FIFO-buffered writer.
// Define VGA_VRAM_ARB_VBLANK_ONLY_EN to restrict FIFO draining to vertical blanking (tear-free).
module vga_vram_arbiter #(
  parameter int VIDEO_WIDTH = 3,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int ADDR_WIDTH  = 19,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic [9:0]                    i_Col_Count,
  input  logic [9:0]                    i_Row_Count,
  input  logic                          i_Wr_Valid,
  input  logic [ADDR_WIDTH-1:0]         i_Wr_Addr,
  input  logic [3*VIDEO_WIDTH-1:0]      i_Wr_Data,
  output logic                          o_Wr_Ready,
  output logic [ADDR_WIDTH-1:0]         o_Ram_Addr,
  output logic                          o_Ram_Wr_En,
  output logic [3*VIDEO_WIDTH-1:0]      o_Ram_Wr_Data,
  input  logic [3*VIDEO_WIDTH-1:0]      i_Ram_Rd_Data,
  output logic [VIDEO_WIDTH-1:0]        o_Red_Video,
  output logic [VIDEO_WIDTH-1:0]        o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0]        o_Blu_Video,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = 3*VIDEO_WIDTH;
  localparam logic [9:0] COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] ROWS = 10'(ACTIVE_ROWS);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  typedef enum logic {DISPLAY, WRITE_WINDOW} owner_t;
  owner_t owner;
  logic active, vblank, full, push, pop, act_q;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH+DW-1:0] mem [FIFO_DEPTH];
  always_comb begin
    active = i_Col_Count < COLS && i_Row_Count < ROWS;
    vblank = i_Row_Count >= ROWS;
`ifdef VGA_VRAM_ARB_VBLANK_ONLY_EN
    owner = vblank ? WRITE_WINDOW : DISPLAY;
`else
    owner = active ? DISPLAY : WRITE_WINDOW;
`endif
    full = o_Fifo_Level == FULL;
    o_Wr_Ready = !full && !i_Rst;
    push = i_Wr_Valid && o_Wr_Ready;
    pop = owner == WRITE_WINDOW && o_Fifo_Level != '0;
    o_Ram_Wr_En = pop;
    // the counter clears on the first vblank edge; gate it so every vblank cycle already reads 0
    o_Ram_Addr = pop ? mem[rd_ptr][ADDR_WIDTH+DW-1:DW] : (vblank ? '0 : rd_cnt);
    o_Ram_Wr_Data = pop ? mem[rd_ptr][DW-1:0] : '0;
  end
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rd_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_Fifo_Level <= '0;
      act_q <= 1'b0;
      {o_Red_Video, o_Grn_Video, o_Blu_Video} <= '0;
    end else begin
      rd_cnt <= vblank ? '0 : (active ? rd_cnt + ADDR_WIDTH'(1) : rd_cnt);
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      o_Fifo_Level <= o_Fifo_Level + (PW+1)'(push) - (PW+1)'(pop);
      act_q <= active;
      {o_Red_Video, o_Grn_Video, o_Blu_Video} <= act_q ? i_Ram_Rd_Data : '0;
    end
  end
  always_ff @(posedge i_Clk) begin
    if (push) mem[wr_ptr] <= {i_Wr_Addr, i_Wr_Data};
  end
endmodule
